// File: rtl/mem_ctrl_if.sv
// CPU data-port bus between the cpu (master) and mem_ctrl (slave).
// Handshake: master raises req with we/addr/wdata and holds them until ready; ready is a one-cycle pulse carrying rdata/err; stall = req & ~ready.
interface mem_ctrl_if #(
  parameter int n = 16
);
  logic         req;
  logic         we;
  logic [n-1:0] addr;
  logic [n-1:0] wdata;
  logic [n-1:0] rdata;
  logic         ready;
  logic         err;
  logic         stall;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, err, stall
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, err, stall
  );
endinterface

// File: rtl/mem_ctrl.sv
// Data-memory controller: wait-stated RAM access, I/O register, free-running cycle counter.
// One request at a time through IDLE -> BUSY -> DONE; the cpu stalls while a request is outstanding.
module mem_ctrl #(
  parameter int n       = 16,
  parameter int DEPTH   = 64,
  parameter int WAIT    = 2,
  parameter int IO_BASE = 'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  mem_ctrl_if.slave   bus,
  output logic [n-1:0] io_out,
  output logic [1:0]  state_dbg
);

  localparam int aw = $clog2(DEPTH);
  localparam logic [n-1:0] io_addr  = n'(IO_BASE);
  localparam logic [n-1:0] cnt_addr = n'(IO_BASE) + n'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, state_n;
  logic [3:0]   wcnt;
  logic         we_q;
  logic [n-1:0] addr_q;
  logic [n-1:0] wdata_q;
  logic [n-1:0] rdata_q;
  logic         err_q;
  logic [n-1:0] cnt;
  logic [n-1:0] mem [DEPTH];

  logic         access;
  logic         misal;
  logic         ram_hit;
  logic         io_hit;
  logic         cnt_hit;
  logic [aw-1:0] idx;
  logic [n-1:0] rd_val;
  logic         acc_err;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.req) state_n = BUSY;
      BUSY:    if (wcnt == 4'd0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign access  = (state == BUSY) && (wcnt == 4'd0);
  assign idx     = addr_q[aw:1];
  assign misal   = addr_q[0];
  assign ram_hit = !misal && (addr_q[n-1:aw+1] == '0);
  assign io_hit  = !misal && (addr_q == io_addr);
  assign cnt_hit = !misal && (addr_q == cnt_addr);

  // Decode is done on the latched address so a dropped req cannot corrupt it.
  always_comb begin
    rd_val  = '0;
    acc_err = 1'b0;
    if (misal) begin
      acc_err = 1'b1;
    end else if (ram_hit) begin
      rd_val = mem[idx];
    end else if (io_hit) begin
      rd_val = io_out;
    end else if (cnt_hit) begin
      rd_val  = cnt;
      acc_err = we_q;
    end else begin
      acc_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt    <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      io_out  <= '0;
      cnt     <= '0;
    end else begin
      cnt <= cnt + n'(1);
      if (state == IDLE && bus.req) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        wcnt    <= 4'(WAIT);
      end else if (state == BUSY && wcnt != 4'd0) begin
        wcnt <= wcnt - 4'd1;
      end
      if (access) begin
        rdata_q <= we_q ? '0 : rd_val;
        err_q   <= acc_err;
        if (we_q && io_hit) io_out <= wdata_q;
      end
    end
  end

  // RAM has no reset; gating with reset makes an abort in BUSY drop the write.
  always_ff @(posedge clk) begin
    if (!reset && access && we_q && ram_hit) mem[idx] <= wdata_q;
  end

  assign bus.ready = (state == DONE);
  assign bus.rdata = bus.ready ? rdata_q : '0;
  assign bus.err   = bus.ready & err_q;
  assign bus.stall = bus.req & ~bus.ready;
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: three instances (WAIT=2, WAIT=0, and an 8-bit variant for counter wrap)
// sharing clock and reset, with a scoreboard queue of expected {err, rdata}.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tb_cnt = 0;

  always @(posedge clk) tb_cnt <= rst ? 0 : tb_cnt + 1;

  logic [16:0] exp_q[$];

  int          sel;
  logic        req, we;
  logic [15:0] addr, wdata;
  logic        rdy, erb, st;
  logic [15:0] rd;

  mem_ctrl_if #(.n(16)) if0 ();
  mem_ctrl_if #(.n(16)) if1 ();
  mem_ctrl_if #(.n(8))  if2 ();

  logic [15:0] io0, io1;
  logic [7:0]  io2;
  logic [1:0]  st0, st1, st2;

  assign if0.req   = req && (sel == 0);
  assign if0.we    = we;
  assign if0.addr  = addr;
  assign if0.wdata = wdata;
  assign if1.req   = req && (sel == 1);
  assign if1.we    = we;
  assign if1.addr  = addr;
  assign if1.wdata = wdata;
  assign if2.req   = req && (sel == 2);
  assign if2.we    = we;
  assign if2.addr  = addr[7:0];
  assign if2.wdata = wdata[7:0];

  assign rdy = (sel == 0) ? if0.ready : (sel == 1) ? if1.ready : if2.ready;
  assign erb = (sel == 0) ? if0.err   : (sel == 1) ? if1.err   : if2.err;
  assign st  = (sel == 0) ? if0.stall : (sel == 1) ? if1.stall : if2.stall;
  assign rd  = (sel == 0) ? if0.rdata : (sel == 1) ? if1.rdata : {8'h00, if2.rdata};

  mem_ctrl #(.n(16), .DEPTH(64), .WAIT(2), .IO_BASE('hFF00)) u0 (
    .clk(clk), .reset(rst), .bus(if0), .io_out(io0), .state_dbg(st0)
  );
  mem_ctrl #(.n(16), .DEPTH(64), .WAIT(0), .IO_BASE('hFF00)) u1 (
    .clk(clk), .reset(rst), .bus(if1), .io_out(io1), .state_dbg(st1)
  );
  mem_ctrl #(.n(8), .DEPTH(16), .WAIT(1), .IO_BASE('hF0)) u2 (
    .clk(clk), .reset(rst), .bus(if2), .io_out(io2), .state_dbg(st2)
  );

  // One complete access on instance s; expectation pushed at drive time, popped at ready.
  task automatic access(input int s, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] er, input logic ee, input bit is_cnt, input bit keep,
                        input string name);
    int          ws;
    logic [15:0] mask;
    logic [16:0] e;
    int          lat;
    bit          seen;
    ws   = (s == 0) ? 2 : (s == 1) ? 0 : 1;
    mask = (s == 2) ? 16'h00FF : 16'hFFFF;
    @(negedge clk);
    sel = s; req = 1'b1; we = w; addr = a; wdata = d;
    if (is_cnt) er = 16'(tb_cnt + ws + 1);
    exp_q.push_back({ee, er & mask});
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin
        lat  = c;
        seen = 1'b1;
        break;
      end
      checks++;
      if (st !== 1'b1) begin
        errors++;
        $display("FAIL %s stall_wait: got %b want 1 (cycle %0d)", name, st, c);
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no ready within 40 cycles", name);
    end else begin
      checks++;
      if (lat !== ws + 2) begin
        errors++;
        $display("FAIL %s latency: got %0d want %0d", name, lat, ws + 2);
      end
      checks++;
      if ({erb, rd} !== e) begin
        errors++;
        $display("FAIL %s data: got err=%b rdata=%h want err=%b rdata=%h", name, erb, rd, e[16], e[15:0]);
      end
      checks++;
      if (st !== 1'b0) begin
        errors++;
        $display("FAIL %s stall_ready: got %b want 0", name, st);
      end
    end
    if (!keep) req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; sel = 0; req = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (if0.ready !== 1'b0 || if0.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_err: got ready=%b err=%b want 0 0", if0.ready, if0.err);
    end
    checks++;
    if (io0 !== 16'h0000 || io1 !== 16'h0000 || io2 !== 8'h00) begin
      errors++;
      $display("FAIL reset_io: got %h %h %h want 0", io0, io1, io2);
    end
    checks++;
    if (st !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_req1: got %b want 1", st);
    end
    checks++;
    if (st0 !== 2'd0 || st1 !== 2'd0 || st2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d %0d %0d want 0", st0, st1, st2);
    end
    req = 1'b0;
    #1;
    checks++;
    if (st !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_req0: got %b want 0", st);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ram_wait2();
    access(0, 1'b1, 16'h0004, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0, "w2_write");
    access(0, 1'b0, 16'h0004, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b0, "w2_read");
  endtask

  task automatic test_io_wait0();
    access(1, 1'b1, 16'hFF00, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, "w0_io_write");
    checks++;
    if (io1 !== 16'h1234) begin
      errors++;
      $display("FAIL w0_io_out: got %h want 1234", io1);
    end
    access(1, 1'b0, 16'hFF00, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, "w0_io_read");
    access(1, 1'b1, 16'h0008, 16'hC0DE, 16'h0000, 1'b0, 1'b0, 1'b0, "w0_ram_write");
    access(1, 1'b0, 16'h0008, 16'h0000, 16'hC0DE, 1'b0, 1'b0, 1'b0, "w0_ram_read");
  endtask

  task automatic test_errors();
    access(0, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "err_misal_read");
    access(0, 1'b1, 16'h0005, 16'h7777, 16'h0000, 1'b1, 1'b0, 1'b0, "err_misal_write");
    access(0, 1'b0, 16'h0004, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b0, "err_misal_nowrite");
    access(0, 1'b1, 16'h0000, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0, "err_pre_write");
    access(0, 1'b1, 16'h0200, 16'h9999, 16'h0000, 1'b1, 1'b0, 1'b0, "err_unmapped_write");
    access(0, 1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0, 1'b0, 1'b0, "err_ram_unchanged");
    access(0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "err_unmapped_read");
    access(0, 1'b0, 16'hFF04, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "err_io_hole_read");
    access(0, 1'b1, 16'hFF02, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "err_cnt_write");
    access(0, 1'b0, 16'hFF02, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, "cnt_read_after_write");
  endtask

  task automatic test_back_to_back();
    access(0, 1'b1, 16'h0020, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 1'b1, "b2b_w1");
    access(0, 1'b0, 16'h0020, 16'h0000, 16'hA5A5, 1'b0, 1'b0, 1'b1, "b2b_r1");
    access(0, 1'b1, 16'h0022, 16'h5A5A, 16'h0000, 1'b0, 1'b0, 1'b1, "b2b_w2");
    access(0, 1'b0, 16'h0022, 16'h0000, 16'h5A5A, 1'b0, 1'b0, 1'b1, "b2b_r2");
    access(0, 1'b0, 16'h0020, 16'h0000, 16'hA5A5, 1'b0, 1'b0, 1'b0, "b2b_r3");
  endtask

  task automatic test_abort();
    access(0, 1'b1, 16'h0010, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b0, "abort_pre");
    @(negedge clk);
    sel = 0; req = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 16'hAAAA;
    @(negedge clk);
    checks++;
    if (st0 !== 2'd1) begin
      errors++;
      $display("FAIL abort_busy: got state %0d want 1", st0);
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rdy !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_ready: got %b want 0 (cycle %0d)", rdy, c);
      end
    end
    req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (st0 !== 2'd0 || rdy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got state=%0d ready=%b want 0 0", st0, rdy);
    end
    access(0, 1'b0, 16'h0010, 16'h0000, 16'h5555, 1'b0, 1'b0, 1'b0, "abort_read_old");
  endtask

  task automatic test_counter_wrap();
    do_reset();
    repeat (200 + $urandom_range(60, 0)) @(negedge clk);
    access(2, 1'b0, 16'h00F2, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, "wrap_cnt_read");
    access(2, 1'b1, 16'h001E, 16'h007C, 16'h0000, 1'b0, 1'b0, 1'b0, "n8_ram_write");
    access(2, 1'b0, 16'h001E, 16'h0000, 16'h007C, 1'b0, 1'b0, 1'b0, "n8_ram_read");
    access(2, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "n8_unmapped_read");
    access(2, 1'b0, 16'h00F2, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, "wrap_cnt_read2");
  endtask

  initial begin
    rst = 1'b1; sel = 0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    test_reset();
    test_ram_wait2();
    test_io_wait0();
    test_errors();
    test_back_to_back();
    test_abort();
    test_counter_wrap();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
